// File: rtl/shader_pkg.sv
// rtl/shader_pkg.sv - shared opcodes, instruction layout, decode helper and FSM states
// Purpose: common definitions imported by the shader issue unit files.
// Contents: opcode constants, instruction bit positions, instr_t decoded
//           struct, decode_instr() helper, state_e enum, scoreboard sizing.
package shader_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_W    = 3;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 14;
  localparam int MASK_HI = 13;
  localparam int MASK_LO = 10;
  localparam int DEST_HI = 9;
  localparam int DEST_LO = 7;
  localparam int SRCA_HI = 6;
  localparam int SRCA_LO = 4;
  localparam int SRCB_HI = 3;
  localparam int SRCB_LO = 1;
  localparam int HALT_B  = 0;

  typedef struct packed {
    logic [1:0]       op;
    logic [3:0]       mask;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] src_a;
    logic [REG_W-1:0] src_b;
    logic             halt;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic instr_t decode_instr(input logic [15:0] w);
    instr_t r;
    r.op    = w[OP_HI:OP_LO];
    r.mask  = w[MASK_HI:MASK_LO];
    r.dest  = w[DEST_HI:DEST_LO];
    r.src_a = w[SRCA_HI:SRCA_LO];
    r.src_b = w[SRCB_HI:SRCB_LO];
    r.halt  = w[HALT_B];
    return r;
  endfunction

endpackage

// File: rtl/shader_issue_unit_if.sv
// rtl/shader_issue_unit_if.sv - host, program memory, issue and writeback signal bundle
// Purpose: groups every non-clock/reset signal of the issue unit.
// Modports: master = issue unit side, slave = host/memory/execute side.
interface shader_issue_unit_if #(parameter int PC_W = 4);

  logic            start;
  logic [PC_W-1:0] start_pc;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rd;
  logic [15:0]     imem_data;
  logic            issue_valid;
  logic            issue_ready;
  logic [1:0]      issue_op;
  logic [3:0]      issue_mask;
  logic [2:0]      issue_dest;
  logic [2:0]      issue_srcA;
  logic [2:0]      issue_srcB;
  logic            wb_valid;
  logic [2:0]      wb_dest;
  logic            busy;
  logic            done;
  logic            overrun;
  logic [PC_W:0]   issued_count;

  modport master (
    input  start, start_pc, imem_data, issue_ready, wb_valid, wb_dest,
    output imem_addr, imem_rd, issue_valid, issue_op, issue_mask,
           issue_dest, issue_srcA, issue_srcB, busy, done, overrun,
           issued_count
  );

  modport slave (
    output start, start_pc, imem_data, issue_ready, wb_valid, wb_dest,
    input  imem_addr, imem_rd, issue_valid, issue_op, issue_mask,
           issue_dest, issue_srcA, issue_srcB, busy, done, overrun,
           issued_count
  );

endinterface

// File: rtl/shader_scoreboard.sv
// rtl/shader_scoreboard.sv - per-register pending-writeback bit vector
// Purpose: tracks registers with an issued but not yet written-back result.
// Ports: set_i/set_idx_i mark a register pending on issue; clr_i/clr_idx_i
//        clear it on writeback; chk_*_i are checked against the registered
//        bits and hazard_o is high if any of them is pending; any_pending_o
//        is high while any bit is set.
module shader_scoreboard
  import shader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_i,
  input  logic [REG_W-1:0] set_idx_i,
  input  logic             clr_i,
  input  logic [REG_W-1:0] clr_idx_i,
  input  logic [REG_W-1:0] chk_a_i,
  input  logic [REG_W-1:0] chk_b_i,
  input  logic [REG_W-1:0] chk_d_i,
  output logic             hazard_o,
  output logic             any_pending_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Set and clear never target the same register in one cycle (issue
  // requires a non-pending dest), so their order here does not matter.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_idx_i] = 1'b0;
    if (set_i) pending_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // Registered bits only: a writeback this cycle is not forwarded.
  assign hazard_o      = pending_q[chk_a_i] | pending_q[chk_b_i] | pending_q[chk_d_i];
  assign any_pending_o = |pending_q;

endmodule

// File: rtl/shader_issue_unit.sv
// rtl/shader_issue_unit.sv - fetch/decode/issue FSM of the SIMD shader front end
// Purpose: fetches instruction words, decodes them and issues them over a
//          valid/ready handshake, stalling on scoreboard hazards.
// Ports: clk, rst (async active-high); bus (master modport) carries host
//        start/done/status, program memory read, issue handshake and
//        writeback notification.
module shader_issue_unit
  import shader_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  shader_issue_unit_if.master bus
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_FETCH = ST_FETCH;
  localparam logic [2:0] S_ISSUE = ST_ISSUE;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W:0]   cnt_q, cnt_d;
  logic            ovr_q, ovr_d;
  instr_t          ir_q, ir_d;
  logic            fresh_q, fresh_d;

  instr_t cur;
  logic   hazard;
  logic   any_pending;
  logic   issue_valid;
  logic   fire;

  // The memory word is only valid in the first ISSUE cycle; afterwards the
  // captured copy keeps the presented fields stable under backpressure.
  always_comb cur = fresh_q ? decode_instr(bus.imem_data) : ir_q;

  assign issue_valid = (state_q == S_ISSUE) && !cur.halt && !hazard;
  assign fire        = issue_valid && bus.issue_ready;

  shader_scoreboard u_sb (
    .clk           (clk),
    .rst           (rst),
    .set_i         (fire),
    .set_idx_i     (cur.dest),
    .clr_i         (bus.wb_valid),
    .clr_idx_i     (bus.wb_dest),
    .chk_a_i       (cur.src_a),
    .chk_b_i       (cur.src_b),
    .chk_d_i       (cur.dest),
    .hazard_o      (hazard),
    .any_pending_o (any_pending)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    ir_d    = ir_q;
    fresh_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pc_d    = bus.start_pc;
          cnt_d   = '0;
          ovr_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        fresh_d = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        ir_d = cur;
        if (cur.halt) begin
          state_d = S_DRAIN;
        end else if (fire) begin
          cnt_d = cnt_q + (PC_W+1)'(1);
          pc_d  = pc_q + PC_W'(1);
          if (pc_q == {PC_W{1'b1}}) begin
            ovr_d   = 1'b1;
            state_d = S_DRAIN;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (!any_pending) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      ir_q    <= '0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      ir_q    <= ir_d;
      fresh_q <= fresh_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.imem_rd      = (state_q == S_FETCH);
  assign bus.issue_valid  = issue_valid;
  assign bus.issue_op     = cur.op;
  assign bus.issue_mask   = cur.mask;
  assign bus.issue_dest   = cur.dest;
  assign bus.issue_srcA   = cur.src_a;
  assign bus.issue_srcB   = cur.src_b;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.overrun      = ovr_q;
  assign bus.issued_count = cnt_q;

endmodule

// File: doc/shader_issue_unit.md
# shader_issue_unit

Front-end issue stage of the SIMD shader processor. Fetches 16-bit instruction words from the synchronous shader program memory and decodes them into op/mask/dest/srcA/srcB. Hands each instruction to the execute stage (register file + SIMD ALU) over a valid/ready handshake, and holds back any instruction whose registers are still awaiting writeback, tracked by a per-register scoreboard. Sits between the program memory and the execute/writeback path; a host asserts `start` and waits for `done`.

## Interface
- `PC_W`, 4: program counter width; program depth is 2^PC_W words.
- `NUM_REGS`, 8: vector registers tracked by the scoreboard; register index width is 3.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin at `start_pc`; ignored unless state is IDLE.
- `start_pc`  in  PC_W  first instruction address, sampled with `start`.
- `imem_addr`  out  PC_W  program memory read address.
- `imem_rd`  out  1  read strobe; data is valid on `imem_data` exactly 1 cycle later.
- `imem_data`  in  16  instruction word: [15:14] op, [13:10] mask, [9:7] dest, [6:4] srcA, [3:1] srcB, [0] halt.
- `issue_valid`  out  1  decoded instruction is presented.
- `issue_ready`  in  1  execute stage accepts; transfer occurs when valid and ready are both high.
- `issue_op` (2), `issue_mask` (4), `issue_dest` (3), `issue_srcA` (3), `issue_srcB` (3)  out  decoded fields, stable while `issue_valid` is high.
- `wb_valid`  in  1  execute stage wrote register `wb_dest` this cycle.
- `wb_dest`  in  3  register being written back.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse on completion.
- `overrun`  out  1  sticky; set when the PC wraps without a halt; cleared by `start`.
- `issued_count`  out  PC_W+1  instructions issued since the last `start`.

## Operation
- States: IDLE, FETCH, ISSUE, DRAIN, DONE.
- IDLE, on `start`:
  - PC is loaded from `start_pc`.
  - `issued_count` and `overrun` are cleared.
  - The scoreboard is not cleared.
  - Next state: FETCH.
- FETCH:
  - `imem_rd` = 1 and `imem_addr` = PC for this one cycle.
  - Next state: ISSUE.
- ISSUE:
  - The word is captured into the instruction register on entry and held until handshake.
  - If halt = 1, nothing is issued and the next state is DRAIN.
  - Otherwise `issue_valid` = !(pending[srcA] | pending[srcB] | pending[dest]), using registered scoreboard bits only (no bypass).
  - On handshake:
    - pending[dest] is set.
    - `issued_count` increments.
    - PC increments.
    - Next state: FETCH.
    - If PC was 2^PC_W-1, the PC wraps to 0, `overrun` is set and the next state is DRAIN instead.
- DRAIN: waits until all pending bits are 0, then goes to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- Scoreboard: `wb_valid` clears pending[`wb_dest`] at the clock edge. A writeback to a non-pending register is ignored.
- Same-cycle set and clear on one register cannot occur, because issue requires dest to be non-pending.
- `issue_valid` may deassert only after a handshake or state change. It never drops while stalled on `issue_ready` once raised.

## Timing
- Reset values:
  - State IDLE, PC = 0, scoreboard all 0.
  - `issue_valid`, `imem_rd`, `busy`, `done`, `overrun` = 0.
  - `issued_count` = 0; all issue fields = 0.
- Latency: with no hazard and `issue_ready` held high, it is 2 cycles per instruction.
  - `start` at cycle 0; FETCH at cycle 1.
  - `issue_valid` high at cycle 2; next FETCH at cycle 3.
- A writeback at edge N clears the pending bit. A dependent instruction can issue at the earliest in cycle N+1.
- Halt costs 2 cycles (FETCH + ISSUE) plus the drain time. `done` follows the last pending clear by 2 cycles (DRAIN exit, then DONE).
- `start` while `busy` has no effect.
- Reset mid-operation returns to IDLE immediately (asynchronous reset). Outstanding writebacks after reset are ignored.

## Structure
- Shared package `shader_pkg`:
  - opcode localparams (ADD, SUB, MUL, AND).
  - instruction field bit positions and the decoded-instruction struct typedef.
  - state enum.
  - `NUM_REGS` and register index width.
- Sub-module `shader_scoreboard` holds the pending bit vector with set/clear ports and a combinational hazard-check output. The FSM, PC and decode logic live in the top.

## Test plan
- Straight line: program with 3 independent instructions, then halt at address 3, `start_pc`=0, ready=1, `wb_valid` pulses 1 cycle after each issue. Required: issues at cycles 2, 4, 6; `done` pulse; `issued_count`=3.
- RAW hazard: ADD r1←r2,r3 then SUB r4←r1,r5; writeback of r1 held off 5 cycles. Required: the second instruction has `issue_valid`=0 until the cycle after `wb_dest`=1.
- Backpressure: `issue_ready`=0 for 4 cycles with an instruction presented. Required: `issue_valid` and all fields stay stable; single transfer; `issued_count` increments by exactly 1.
- Wrap: `start_pc`=14, no halt at 14 or 15. Required: 2 issues, `overrun`=1, DRAIN, `done`; `overrun` cleared by the next `start`.
- Drain: halt reached with r6 pending; `wb_dest`=6 arrives 7 cycles later. Required: `done` 2 cycles after that writeback; `start` during DRAIN is ignored.
- Async reset asserted mid-ISSUE with pending bits set. Required: all outputs at reset values immediately; a subsequent `start` runs normally with an empty scoreboard.
